drivetrain_model: RTL and testbench

Parametrised successor to the single-ratio speed/rpm model, stepped by `tick_10hz`. It adds a configurable gear table, a shift state machine with a timed clutch phase and over-rev protection on manual requests, an automatic-transmission mode, a rev limiter, and a sticky overload fault. It sits between the input debouncers and the dashboard/LCD renderer, and supplies speed, rpm, engaged gear and status flags.

---
 rtl/drivetrain_model.sv | 199 +++++++++++++++++++
 tb/tb_drivetrain_model.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drivetrain_model.sv
// Vehicle drivetrain model stepped by a 10 Hz tick: gear table, timed shift FSM,
// automatic mode, rev limiter, and a sticky overload fault.
//
// state   | meaning
// NEUTRAL | no gear engaged, rpm held at idle
// DRIVE   | gear 1..NUM_GEARS engaged, throttle effective
// SHIFT   | clutch phase towards target, lasts SHIFT_TICKS ticks
module drivetrain_model #(
  parameter int NUM_GEARS      = 6,
  parameter int SPEED_W        = 9,
  parameter int RPM_W          = 14,
  parameter int SPEED_MAX      = 400,
  parameter int IDLE_RPM       = 800,
  parameter int OVERLOAD_RPM   = 7000,
  parameter int RPM_LIMIT      = 8000,
  parameter int UPSHIFT_RPM    = 6000,
  parameter int DOWNSHIFT_RPM  = 2000,
  parameter int SHIFT_TICKS    = 3,
  parameter int OVERLOAD_TICKS = 20,
  parameter int BRAKE_STEP     = 6,
  parameter logic [NUM_GEARS*16-1:0] GEAR_K =
    {16'd320, 16'd427, 16'd640, 16'd985, 16'd1829, 16'd4267},
  parameter logic [NUM_GEARS*SPEED_W-1:0] GEAR_VMAX =
    {9'd400, 9'd300, 9'd200, 9'd130, 9'd70, 9'd30},
  parameter logic [NUM_GEARS*4-1:0] GEAR_ACCEL =
    {4'd6, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_10hz,
  input  logic               throttle,
  input  logic               brake,
  input  logic               mode_auto,
  input  logic               gear_req_valid,
  input  logic [2:0]         gear_req,
  input  logic               fault_clr,
  output logic [SPEED_W-1:0] speed_kmh,
  output logic [RPM_W-1:0]   rpm,
  output logic [2:0]         gear,
  output logic               shifting,
  output logic               rev_limit,
  output logic               overload,
  output logic               overload_fault,
  output logic               shift_ack,
  output logic               shift_reject
);

  localparam int PROD_W = SPEED_W + 16;
  localparam int SW1    = SPEED_W + 1;
  localparam logic [7:0] SHIFT_T = 8'(SHIFT_TICKS);
  localparam logic [7:0] OVL_T   = 8'(OVERLOAD_TICKS);

  typedef enum logic [1:0] {NEUTRAL, DRIVE, SHIFT} state_t;

  state_t       state;
  logic [2:0]   target;
  logic [7:0]   shift_cnt;
  logic [7:0]   ovl_cnt;

  function automatic logic [15:0] k_of(input logic [2:0] g);
    int idx;
    idx = int'(g) - 1;
    if (idx < 0 || idx >= NUM_GEARS) return 16'd0;
    return GEAR_K[idx*16 +: 16];
  endfunction

  function automatic logic [SPEED_W-1:0] vmax_of(input logic [2:0] g);
    int idx;
    idx = int'(g) - 1;
    if (idx < 0 || idx >= NUM_GEARS) return '0;
    return GEAR_VMAX[idx*SPEED_W +: SPEED_W];
  endfunction

  function automatic logic [3:0] accel_of(input logic [2:0] g);
    int idx;
    idx = int'(g) - 1;
    if (idx < 0 || idx >= NUM_GEARS) return 4'd0;
    return GEAR_ACCEL[idx*4 +: 4];
  endfunction

  // Unclamped engine speed for a road speed in a given ratio.
  function automatic logic [PROD_W-1:0] raw_rpm(input logic [SPEED_W-1:0] s,
                                                input logic [15:0] k);
    logic [PROD_W-1:0] p;
    p = PROD_W'(s) * PROD_W'(k);
    return p >> 4;
  endfunction

  function automatic logic [RPM_W-1:0] clamp_rpm(input logic [PROD_W-1:0] r);
    if (r < PROD_W'(IDLE_RPM))  return RPM_W'(IDLE_RPM);
    if (r > PROD_W'(RPM_LIMIT)) return RPM_W'(RPM_LIMIT);
    return r[RPM_W-1:0];
  endfunction

  logic [SPEED_W-1:0] cap_v, speed_nxt;
  logic [SW1-1:0]     spd_sum;
  logic [RPM_W-1:0]   rpm_nxt;
  logic [2:0]         eff_gear, auto_tgt;
  logic               eff_drive, shift_done, req_ok, auto_go, fault_set;
  logic [7:0]         ovl_inc;

  assign shifting  = (state == SHIFT);
  assign rev_limit = (rpm >= RPM_W'(RPM_LIMIT));
  assign overload  = (rpm >= RPM_W'(OVERLOAD_RPM));

  always_comb begin
    cap_v = vmax_of(gear);
    if (cap_v > SPEED_W'(SPEED_MAX)) cap_v = SPEED_W'(SPEED_MAX);
    spd_sum = {1'b0, speed_kmh} + SW1'(accel_of(gear));

    speed_nxt = speed_kmh;
    if (brake)
      speed_nxt = (speed_kmh < SPEED_W'(BRAKE_STEP)) ? '0 : speed_kmh - SPEED_W'(BRAKE_STEP);
    else if (throttle && state == DRIVE) begin
      // Held throttle at the cap or on the limiter keeps speed instead of coasting.
      if (!rev_limit && speed_kmh < cap_v)
        speed_nxt = (spd_sum > SW1'(cap_v)) ? cap_v : spd_sum[SPEED_W-1:0];
    end else if (speed_kmh != '0)
      speed_nxt = speed_kmh - SPEED_W'(1);

    shift_done = (state == SHIFT) && tick_10hz && (shift_cnt + 8'd1 >= SHIFT_T);
    eff_gear   = gear;
    eff_drive  = (state == DRIVE);
    if (shift_done) begin
      eff_gear  = target;
      eff_drive = (target != 3'd0);
    end
    rpm_nxt = eff_drive ? clamp_rpm(raw_rpm(speed_nxt, k_of(eff_gear))) : RPM_W'(IDLE_RPM);

    req_ok = !mode_auto && state != SHIFT &&
             (gear_req == 3'd0 ||
              (int'(gear_req) <= NUM_GEARS && gear_req != gear &&
               raw_rpm(speed_kmh, k_of(gear_req)) <= PROD_W'(RPM_LIMIT)));

    auto_go  = 1'b0;
    auto_tgt = gear;
    if (mode_auto && tick_10hz) begin
      if (state == NEUTRAL && throttle) begin
        auto_go  = 1'b1;
        auto_tgt = 3'd1;
      end else if (state == DRIVE && rpm >= RPM_W'(UPSHIFT_RPM) && int'(gear) < NUM_GEARS) begin
        auto_go  = 1'b1;
        auto_tgt = gear + 3'd1;
      end else if (state == DRIVE && rpm < RPM_W'(DOWNSHIFT_RPM) && gear > 3'd1) begin
        auto_go  = 1'b1;
        auto_tgt = gear - 3'd1;
      end
    end

    ovl_inc   = (ovl_cnt == 8'hFF) ? ovl_cnt : ovl_cnt + 8'd1;
    fault_set = tick_10hz && overload && (ovl_inc >= OVL_T);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= NEUTRAL;
      speed_kmh      <= '0;
      rpm            <= RPM_W'(IDLE_RPM);
      gear           <= 3'd0;
      target         <= 3'd0;
      shift_cnt      <= 8'd0;
      ovl_cnt        <= 8'd0;
      overload_fault <= 1'b0;
      shift_ack      <= 1'b0;
      shift_reject   <= 1'b0;
    end else begin
      shift_ack    <= gear_req_valid && req_ok;
      shift_reject <= gear_req_valid && !req_ok;

      if (tick_10hz) begin
        speed_kmh <= speed_nxt;
        rpm       <= rpm_nxt;
        ovl_cnt   <= overload ? ovl_inc : 8'd0;
      end

      if (fault_set)      overload_fault <= 1'b1;
      else if (fault_clr) overload_fault <= 1'b0;

      if (gear_req_valid && req_ok) begin
        target    <= gear_req;
        state     <= SHIFT;
        shift_cnt <= 8'd0;
      end else if (auto_go) begin
        target    <= auto_tgt;
        state     <= SHIFT;
        shift_cnt <= 8'd0;
      end else if (state == SHIFT && tick_10hz) begin
        if (shift_done) begin
          gear      <= target;
          state     <= (target == 3'd0) ? NEUTRAL : DRIVE;
          shift_cnt <= 8'd0;
        end else begin
          shift_cnt <= shift_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_drivetrain_model.sv
// Bench for drivetrain_model: directed scenarios against hand-derived values, then
// randomized traffic against a cycle-level reference model.
module tb_drivetrain_model;

  logic clk = 1'b0;
  logic rst, tick_10hz, throttle, brake, mode_auto, gear_req_valid, fault_clr;
  logic [2:0]  gear_req;
  logic [8:0]  speed_kmh;
  logic [13:0] rpm;
  logic [2:0]  gear;
  logic shifting, rev_limit, overload, overload_fault, shift_ack, shift_reject;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  drivetrain_model dut (
    .clk(clk), .rst(rst), .tick_10hz(tick_10hz), .throttle(throttle), .brake(brake),
    .mode_auto(mode_auto), .gear_req_valid(gear_req_valid), .gear_req(gear_req),
    .fault_clr(fault_clr), .speed_kmh(speed_kmh), .rpm(rpm), .gear(gear),
    .shifting(shifting), .rev_limit(rev_limit), .overload(overload),
    .overload_fault(overload_fault), .shift_ack(shift_ack), .shift_reject(shift_reject)
  );

  // Reference model: gear tables indexed by gear number, vehicle kept as plain integers.
  int K[8]    = '{0, 4267, 1829, 985, 640, 427, 320, 0};
  int VMAX[8] = '{0, 30, 70, 130, 200, 300, 400, 0};
  int ACC[8]  = '{0, 2, 3, 4, 5, 6, 6, 0};

  int m_speed, m_rpm, m_gear, m_target, m_cnt, m_ovl;
  bit m_in_shift, m_fault, m_ack, m_rej;

  function automatic int rpm_in(int s, int g);
    int r;
    r = s * K[g] / 16;
    if (r < 800) r = 800;
    if (r > 8000) r = 8000;
    return r;
  endfunction

  task automatic model_reset();
    m_speed = 0; m_rpm = 800; m_gear = 0; m_target = 0; m_cnt = 0; m_ovl = 0;
    m_in_shift = 0; m_fault = 0; m_ack = 0; m_rej = 0;
  endtask

  task automatic model_step();
    int ns, nr, cap, req, tgt, novl;
    bit driving, done, ok, go, fset;
    driving = !m_in_shift && m_gear != 0;
    ns = m_speed; nr = m_rpm; novl = m_ovl; done = 0; go = 0; fset = 0; tgt = 0;
    if (tick_10hz) begin
      if (brake) ns = (m_speed > 6) ? m_speed - 6 : 0;
      else if (throttle && driving) begin
        cap = (VMAX[m_gear] < 400) ? VMAX[m_gear] : 400;
        if (m_rpm < 8000 && m_speed < cap)
          ns = (m_speed + ACC[m_gear] > cap) ? cap : m_speed + ACC[m_gear];
      end else ns = (m_speed > 0) ? m_speed - 1 : 0;
      done = m_in_shift && (m_cnt + 1 >= 3);
      if (done) nr = (m_target != 0) ? rpm_in(ns, m_target) : 800;
      else nr = driving ? rpm_in(ns, m_gear) : 800;
      if (m_rpm >= 7000) begin
        novl = (m_ovl < 255) ? m_ovl + 1 : 255;
        fset = (novl >= 20);
      end else novl = 0;
    end
    req = int'(gear_req);
    ok = !mode_auto && !m_in_shift &&
         (req == 0 || (req <= 6 && req != m_gear && m_speed * K[req] / 16 <= 8000));
    if (mode_auto && tick_10hz && !m_in_shift) begin
      if (m_gear == 0 && throttle) begin go = 1; tgt = 1; end
      else if (m_gear != 0 && m_rpm >= 6000 && m_gear < 6) begin go = 1; tgt = m_gear + 1; end
      else if (m_gear != 0 && m_rpm < 2000 && m_gear > 1) begin go = 1; tgt = m_gear - 1; end
    end
    m_ack = gear_req_valid && ok;
    m_rej = gear_req_valid && !ok;
    if (tick_10hz) begin m_speed = ns; m_rpm = nr; m_ovl = novl; end
    if (fset) m_fault = 1;
    else if (fault_clr) m_fault = 0;
    if (gear_req_valid && ok) begin m_target = req; m_in_shift = 1; m_cnt = 0; end
    else if (go) begin m_target = tgt; m_in_shift = 1; m_cnt = 0; end
    else if (m_in_shift && tick_10hz) begin
      if (done) begin m_gear = m_target; m_in_shift = 0; m_cnt = 0; end
      else m_cnt = m_cnt + 1;
    end
  endtask

  // One clock: model advances on the same edge, outputs are then sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    tick_10hz = 0; gear_req_valid = 0; fault_clr = 0;
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin tick_10hz = 1; step(); end
  endtask

  task automatic do_req(input logic [2:0] g);
    gear_req_valid = 1; gear_req = g; step();
  endtask

  task automatic reset_dut();
    throttle = 0; brake = 0; mode_auto = 0; rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    do_req(3'd1); do_ticks(3);
    throttle = 1; do_ticks(5);
    throttle = 0; do_req(3'd2);
    rst = 1; #1;
    checks++; if (speed_kmh !== 9'd0) begin failures++; $display("FAIL reset_speed got=%0d exp=0", speed_kmh); end
    checks++; if (rpm !== 14'd800) begin failures++; $display("FAIL reset_rpm got=%0d exp=800", rpm); end
    checks++; if (gear !== 3'd0) begin failures++; $display("FAIL reset_gear got=%0d exp=0", gear); end
    checks++; if ({shifting, rev_limit, overload, overload_fault, shift_ack, shift_reject} !== 6'b0)
      begin failures++; $display("FAIL reset_flags got=%b exp=000000",
        {shifting, rev_limit, overload, overload_fault, shift_ack, shift_reject}); end
    step();
    rst = 0;
  endtask

  task automatic test_manual_launch();
    reset_dut();
    do_req(3'd1);
    checks++; if (shift_ack !== 1'b1 || shifting !== 1'b1) begin failures++;
      $display("FAIL launch_ack got ack=%b shifting=%b exp=1,1", shift_ack, shifting); end
    do_ticks(2);
    checks++; if (gear !== 3'd0 || shifting !== 1'b1) begin failures++;
      $display("FAIL launch_midshift got gear=%0d shifting=%b exp=0,1", gear, shifting); end
    do_ticks(1);
    checks++; if (gear !== 3'd1 || shifting !== 1'b0) begin failures++;
      $display("FAIL launch_gear got gear=%0d shifting=%b exp=1,0", gear, shifting); end
    throttle = 1; do_ticks(15);
    checks++; if (speed_kmh !== 9'd30 || rpm !== 14'd8000 || rev_limit !== 1'b1) begin failures++;
      $display("FAIL launch_top got speed=%0d rpm=%0d rl=%b exp=30,8000,1", speed_kmh, rpm, rev_limit); end
    do_ticks(1);
    checks++; if (speed_kmh !== 9'd30) begin failures++;
      $display("FAIL launch_hold got speed=%0d exp=30", speed_kmh); end
  endtask

  task automatic test_upshift();
    throttle = 0;
    do_req(3'd2);
    checks++; if (shift_ack !== 1'b1) begin failures++; $display("FAIL upshift_ack got=%b exp=1", shift_ack); end
    for (int i = 1; i <= 3; i++) begin
      do_ticks(1);
      checks++; if (int'(speed_kmh) != 30 - i || (i < 3 && rpm !== 14'd800) || shifting !== (i < 3)) begin
        failures++; $display("FAIL upshift_tick%0d got speed=%0d rpm=%0d shifting=%b exp speed=%0d",
          i, speed_kmh, rpm, shifting, 30 - i); end
    end
    checks++; if (gear !== 3'd2 || rpm !== 14'd3086) begin failures++;
      $display("FAIL upshift_done got gear=%0d rpm=%0d exp=2,3086", gear, rpm); end
  endtask

  task automatic test_over_rev();
    throttle = 1; do_ticks(11);
    throttle = 0;
    checks++; if (speed_kmh !== 9'd60) begin failures++; $display("FAIL overrev_speed got=%0d exp=60", speed_kmh); end
    do_req(3'd1);
    checks++; if (shift_reject !== 1'b1 || shift_ack !== 1'b0) begin failures++;
      $display("FAIL overrev_reject got rej=%b ack=%b exp=1,0", shift_reject, shift_ack); end
    step();
    checks++; if (shift_reject !== 1'b0 || gear !== 3'd2 || shifting !== 1'b0) begin failures++;
      $display("FAIL overrev_after got rej=%b gear=%0d shifting=%b exp=0,2,0", shift_reject, gear, shifting); end
    do_req(3'd7);
    checks++; if (shift_reject !== 1'b1) begin failures++; $display("FAIL req7_reject got=%b exp=1", shift_reject); end
    do_req(3'd2);
    checks++; if (shift_reject !== 1'b1 || gear !== 3'd2) begin failures++;
      $display("FAIL same_gear_reject got rej=%b gear=%0d exp=1,2", shift_reject, gear); end
  endtask

  task automatic test_overload();
    reset_dut();
    do_req(3'd1); do_ticks(3);
    throttle = 1; do_ticks(33);
    checks++; if (overload !== 1'b1 || overload_fault !== 1'b0) begin failures++;
      $display("FAIL overload_pre got ovl=%b fault=%b exp=1,0", overload, overload_fault); end
    do_ticks(1);
    checks++; if (overload_fault !== 1'b1) begin failures++; $display("FAIL overload_set got=%b exp=1", overload_fault); end
    throttle = 0; brake = 1; do_ticks(6);
    brake = 0;
    checks++; if (speed_kmh !== 9'd0 || overload !== 1'b0 || overload_fault !== 1'b1) begin failures++;
      $display("FAIL overload_sticky got speed=%0d ovl=%b fault=%b exp=0,0,1", speed_kmh, overload, overload_fault); end
    fault_clr = 1; step();
    checks++; if (overload_fault !== 1'b0) begin failures++; $display("FAIL overload_clr got=%b exp=0", overload_fault); end
  endtask

  task automatic test_auto();
    int n;
    bit acked, skipped;
    reset_dut();
    mode_auto = 1; throttle = 1;
    do_ticks(1);
    checks++; if (shifting !== 1'b1 || shift_ack !== 1'b0) begin failures++;
      $display("FAIL auto_launch got shifting=%b ack=%b exp=1,0", shifting, shift_ack); end
    do_ticks(3);
    checks++; if (gear !== 3'd1) begin failures++; $display("FAIL auto_gear1 got=%0d exp=1", gear); end
    do_req(3'd3);
    checks++; if (shift_reject !== 1'b1) begin failures++; $display("FAIL auto_manual_reject got=%b exp=1", shift_reject); end
    n = 0; acked = 0;
    while (gear != 3'd2 && n < 40) begin do_ticks(1); n++; if (shift_ack) acked = 1; end
    checks++; if (gear !== 3'd2 || speed_kmh !== 9'd23 || rpm !== 14'd2629 || acked) begin failures++;
      $display("FAIL auto_upshift got gear=%0d speed=%0d rpm=%0d ack_seen=%b exp=2,23,2629,0",
        gear, speed_kmh, rpm, acked); end
    throttle = 0;
    n = 0; skipped = 0;
    while (gear != 3'd1 && n < 60) begin do_ticks(1); n++; if (gear != 3'd1 && gear != 3'd2) skipped = 1; end
    checks++; if (gear !== 3'd1 || speed_kmh !== 9'd13 || rpm !== 14'd3466 || skipped) begin failures++;
      $display("FAIL auto_downshift got gear=%0d speed=%0d rpm=%0d skipped=%b exp=1,13,3466,0",
        gear, speed_kmh, rpm, skipped); end
    mode_auto = 0;
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 5000; c++) begin
      rst            = ($urandom_range(0, 999) == 0);
      tick_10hz      = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) throttle = ~throttle;
      if ($urandom_range(0, 39) == 0) brake = ~brake;
      if ($urandom_range(0, 199) == 0) mode_auto = ~mode_auto;
      gear_req_valid = ($urandom_range(0, 19) == 0);
      gear_req       = 3'($urandom_range(0, 7));
      fault_clr      = ($urandom_range(0, 49) == 0);
      step();
      checks++; if (speed_kmh !== 9'(m_speed)) begin failures++;
        $display("FAIL rnd_speed cyc=%0d got=%0d exp=%0d", c, speed_kmh, m_speed); end
      checks++; if (rpm !== 14'(m_rpm)) begin failures++;
        $display("FAIL rnd_rpm cyc=%0d got=%0d exp=%0d", c, rpm, m_rpm); end
      checks++; if (gear !== 3'(m_gear)) begin failures++;
        $display("FAIL rnd_gear cyc=%0d got=%0d exp=%0d", c, gear, m_gear); end
      checks++; if (shifting !== m_in_shift) begin failures++;
        $display("FAIL rnd_shifting cyc=%0d got=%b exp=%b", c, shifting, m_in_shift); end
      checks++; if (rev_limit !== (m_rpm >= 8000) || overload !== (m_rpm >= 7000)) begin failures++;
        $display("FAIL rnd_rpm_flags cyc=%0d got rl=%b ovl=%b rpm_exp=%0d", c, rev_limit, overload, m_rpm); end
      checks++; if (overload_fault !== m_fault) begin failures++;
        $display("FAIL rnd_fault cyc=%0d got=%b exp=%b", c, overload_fault, m_fault); end
      checks++; if (shift_ack !== m_ack || shift_reject !== m_rej) begin failures++;
        $display("FAIL rnd_pulses cyc=%0d got ack=%b rej=%b exp ack=%b rej=%b",
          c, shift_ack, shift_reject, m_ack, m_rej); end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; tick_10hz = 0; throttle = 0; brake = 0; mode_auto = 0;
    gear_req_valid = 0; gear_req = 3'd0; fault_clr = 0;
    model_reset();
    test_reset();
    test_manual_launch();
    test_upshift();
    test_over_rev();
    test_overload();
    test_auto();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
